// File: rtl/conv_tile_engine.sv
// conv_tile_engine
//   Tiled int8 convolution engine. An IFM buffer (4 int8 channels per
//   32-bit word) and NUM_PE weight banks are loaded while idle. A start
//   command then walks every output pixel in raster order. For each pixel
//   it issues K*K*cfg_cw reads, and each PE accumulates a 4-way signed byte
//   dot product per read. The accumulator is shifted right, saturated to
//   int8 and offered on a valid/ready output port.
//
//   Optional build macro: CONV_TILE_RELU_EN -- clamp negative output bytes
//   to zero.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   wr_addr, we_ifm,        buffer load port (honoured only while idle);
//   we_weight, wdata_ifm,   wdata_w carries one 32-bit word per weight bank
//   wdata_w
//   cfg_*                   job configuration, sampled on start
//   start, busy, done       job control / status (done is a 1-cycle pulse)
//   ofm_valid, ofm_ready,   output pixel handshake; ofm_data carries one
//   ofm_data, ofm_index     byte per PE; ofm_index is the raster pixel number
module conv_tile_engine #(
    parameter int NUM_PE    = 16,
    parameter int IFM_DEPTH = 4096,
    parameter int W_DEPTH   = 1024,
    parameter int ACC_W     = 32
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [31:0]            wr_addr,
    input  logic                   we_ifm,
    input  logic                   we_weight,
    input  logic [31:0]            wdata_ifm,
    input  logic [NUM_PE*32-1:0]   wdata_w,
    input  logic [3:0]             cfg_kernel_w,
    input  logic [7:0]             cfg_ifm_w,
    input  logic [7:0]             cfg_cw,
    input  logic [7:0]             cfg_ofm_w,
    input  logic [1:0]             cfg_stride,
    input  logic [4:0]             cfg_shift,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   ofm_valid,
    input  logic                   ofm_ready,
    output logic [NUM_PE*8-1:0]    ofm_data,
    output logic [15:0]            ofm_index
);

    localparam int IAW = $clog2(IFM_DEPTH);
    localparam int WAW = $clog2(W_DEPTH);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;

    state_t state_q, state_d;

    // Sampled configuration
    logic [3:0] k_q;
    logic [7:0] ifm_w_q, cw_q, ofm_w_q;
    logic [1:0] stride_q;
    logic [4:0] shift_q;

    // Read walk counters and pixel position
    logic [7:0] c_q;
    logic [3:0] kx_q, ky_q;
    logic [7:0] x_q, y_q;

    logic                   rd_valid_q;
    logic [31:0]            ifm_rd_q;
    logic [NUM_PE*32-1:0]   w_rd_q;
    logic signed [ACC_W-1:0] acc_q [NUM_PE];
    logic signed [ACC_W-1:0] dot   [NUM_PE];
    logic [NUM_PE*8-1:0]    ofm_next;

    logic [31:0] ifm_mem [IFM_DEPTH];
    logic [NUM_PE*32-1:0] w_mem [W_DEPTH];

    logic cfg_zero, start_job, last_c, last_kx, last_ky, last_read;
    logic xfer, last_pix, start_run;
    logic [1:0]  s_eff;
    logic [31:0] row, col, ifm_lin, w_lin;
    logic [IAW-1:0] ifm_addr;
    logic [WAW-1:0] w_addr;
    logic unused_bits;

    function automatic logic signed [17:0] dot4(input logic [31:0] a, input logic [31:0] b);
        logic signed [17:0] s;
        s = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            s = s + 18'(signed'(a[8*i +: 8])) * 18'(signed'(b[8*i +: 8]));
        end
        return s;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [ACC_W-1:0] a, input logic [4:0] sh);
        logic signed [ACC_W-1:0] v;
        logic [7:0] r;
        v = a >>> sh;
        if (v > ACC_W'(127))
            r = 8'h7F;
        else if (v < ACC_W'(-128))
            r = 8'h80;
        else
            r = v[7:0];
`ifdef CONV_TILE_RELU_EN
        if (r[7])
            r = 8'h00;
`else
        r = r;
`endif
        return r;
    endfunction

    assign cfg_zero  = (cfg_kernel_w == 4'd0) || (cfg_cw == 8'd0) || (cfg_ofm_w == 8'd0);
    assign start_job = (state_q == IDLE) && start && !cfg_zero;
    assign last_c    = (c_q  == cw_q - 8'd1);
    assign last_kx   = (kx_q == k_q - 4'd1);
    assign last_ky   = (ky_q == k_q - 4'd1);
    assign last_read = last_c && last_kx && last_ky;
    assign xfer      = (state_q == OUT) && ofm_valid && ofm_ready;
    assign last_pix  = (x_q == ofm_w_q - 8'd1) && (y_q == ofm_w_q - 8'd1);
    assign start_run = start_job || (xfer && !last_pix);

    // Address generation; buffer depths are powers of two, so truncation is the modulo.
    assign s_eff    = (stride_q == 2'd0) ? 2'd1 : stride_q;
    assign row      = 32'(y_q) * 32'(s_eff) + 32'(ky_q);
    assign col      = 32'(x_q) * 32'(s_eff) + 32'(kx_q);
    assign ifm_lin  = (row * 32'(ifm_w_q) + col) * 32'(cw_q) + 32'(c_q);
    assign w_lin    = (32'(ky_q) * 32'(k_q) + 32'(kx_q)) * 32'(cw_q) + 32'(c_q);
    assign ifm_addr = ifm_lin[IAW-1:0];
    assign w_addr   = w_lin[WAW-1:0];
    assign unused_bits = ^{wr_addr, ifm_lin, w_lin};

    // Buffers: writes only while idle, registered reads every cycle.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && we_ifm)
            ifm_mem[wr_addr[IAW-1:0]] <= wdata_ifm;
        if ((state_q == IDLE) && we_weight)
            w_mem[wr_addr[WAW-1:0]] <= wdata_w;
        ifm_rd_q <= ifm_mem[ifm_addr];
        w_rd_q   <= w_mem[w_addr];
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_PE; p++)
            dot[p] = ACC_W'(dot4(ifm_rd_q, w_rd_q[32*p +: 32]));
    end

    always_comb begin
        ofm_next = '0;
        for (int unsigned p = 0; p < NUM_PE; p++)
            ofm_next[8*p +: 8] = sat8(acc_q[p], shift_q);
    end

    // FSM
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            IDLE:  if (start) state_d = cfg_zero ? DONE : RUN;
            RUN:   if (last_read) state_d = DRAIN;
            DRAIN: state_d = OUT;
            OUT:   if (xfer) state_d = last_pix ? DONE : RUN;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Configuration, counters and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q        <= '0;
            ifm_w_q    <= '0;
            cw_q       <= '0;
            ofm_w_q    <= '0;
            stride_q   <= '0;
            shift_q    <= '0;
            c_q        <= '0;
            kx_q       <= '0;
            ky_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rd_valid_q <= 1'b0;
            ofm_valid  <= 1'b0;
            ofm_data   <= '0;
            ofm_index  <= '0;
        end else begin
            rd_valid_q <= (state_q == RUN);
            if ((state_q == IDLE) && start) begin
                k_q      <= cfg_kernel_w;
                ifm_w_q  <= cfg_ifm_w;
                cw_q     <= cfg_cw;
                ofm_w_q  <= cfg_ofm_w;
                stride_q <= cfg_stride;
                shift_q  <= cfg_shift;
                c_q      <= '0;
                kx_q     <= '0;
                ky_q     <= '0;
                x_q      <= '0;
                y_q      <= '0;
            end
            // The walk wraps back to zero on the last read, ready for the next pixel.
            if (state_q == RUN) begin
                if (last_c) begin
                    c_q <= '0;
                    if (last_kx) begin
                        kx_q <= '0;
                        ky_q <= last_ky ? 4'd0 : ky_q + 4'd1;
                    end else begin
                        kx_q <= kx_q + 4'd1;
                    end
                end else begin
                    c_q <= c_q + 8'd1;
                end
            end
            // OUT spends its first cycle loading the output register from the final
            // accumulators, then holds it until the handshake completes.
            if ((state_q == OUT) && !ofm_valid) begin
                ofm_valid <= 1'b1;
                ofm_data  <= ofm_next;
                ofm_index <= 16'(y_q) * 16'(ofm_w_q) + 16'(x_q);
            end else if (xfer) begin
                ofm_valid <= 1'b0;
                if (!last_pix) begin
                    if (x_q == ofm_w_q - 8'd1) begin
                        x_q <= '0;
                        y_q <= y_q + 8'd1;
                    end else begin
                        x_q <= x_q + 8'd1;
                    end
                end
            end
        end
    end

    // Accumulators: cleared at each pixel start, one read word added per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned p = 0; p < NUM_PE; p++)
                acc_q[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PE; p++) begin
                if (start_run)
                    acc_q[p] <= '0;
                else if (rd_valid_q)
                    acc_q[p] <= acc_q[p] + dot[p];
            end
        end
    end

endmodule

// File: tb/tb_conv_tile_engine.sv
module tb_conv_tile_engine;

    localparam int NUM_PE    = 4;
    localparam int IFM_DEPTH = 256;
    localparam int W_DEPTH   = 64;
    localparam int ACC_W     = 32;

    logic                 clk;
    logic                 reset_n;
    logic [31:0]          wr_addr;
    logic                 we_ifm, we_weight;
    logic [31:0]          wdata_ifm;
    logic [NUM_PE*32-1:0] wdata_w;
    logic [3:0]           cfg_kernel_w;
    logic [7:0]           cfg_ifm_w, cfg_cw, cfg_ofm_w;
    logic [1:0]           cfg_stride;
    logic [4:0]           cfg_shift;
    logic                 start, busy, done;
    logic                 ofm_valid, ofm_ready;
    logic [NUM_PE*8-1:0]  ofm_data;
    logic [15:0]          ofm_index;

    int errors = 0;
    int checks = 0;

    logic [31:0] ifm_m [IFM_DEPTH];
    logic [31:0] w_m   [NUM_PE][W_DEPTH];

    conv_tile_engine #(
        .NUM_PE(NUM_PE),
        .IFM_DEPTH(IFM_DEPTH),
        .W_DEPTH(W_DEPTH),
        .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_addr(wr_addr), .we_ifm(we_ifm), .we_weight(we_weight),
        .wdata_ifm(wdata_ifm), .wdata_w(wdata_w),
        .cfg_kernel_w(cfg_kernel_w), .cfg_ifm_w(cfg_ifm_w), .cfg_cw(cfg_cw),
        .cfg_ofm_w(cfg_ofm_w), .cfg_stride(cfg_stride), .cfg_shift(cfg_shift),
        .start(start), .busy(busy), .done(done),
        .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
        .ofm_data(ofm_data), .ofm_index(ofm_index)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int sbyte(input logic [31:0] w, input int i);
        logic [7:0] b;
        b = 8'(w >> (8*i));
        return int'(signed'(b));
    endfunction

    function automatic logic [NUM_PE*8-1:0] model_pixel(input int k, input int iw, input int cw,
                                                        input int s, input int sh, input int x, input int y);
        logic [NUM_PE*8-1:0] res;
        int se, acc, v, ia, wa;
        res = '0;
        se = (s == 0) ? 1 : s;
        for (int p = 0; p < NUM_PE; p++) begin
            acc = 0;
            for (int ky = 0; ky < k; ky++)
                for (int kx = 0; kx < k; kx++)
                    for (int c = 0; c < cw; c++) begin
                        ia = (((y*se + ky)*iw + x*se + kx)*cw + c) % IFM_DEPTH;
                        wa = ((ky*k + kx)*cw + c) % W_DEPTH;
                        for (int b = 0; b < 4; b++)
                            acc += sbyte(ifm_m[ia], b) * sbyte(w_m[p][wa], b);
                    end
            v = acc >>> sh;
            if (v > 127)  v = 127;
            if (v < -128) v = -128;
`ifdef CONV_TILE_RELU_EN
            if (v < 0) v = 0;
`endif
            res[8*p +: 8] = 8'(v);
        end
        return res;
    endfunction

    // ---------------- buffer load ----------------
    task automatic write_ifm(input int unsigned addr, input logic [31:0] d);
        @(negedge clk);
        wr_addr = addr; wdata_ifm = d; we_ifm = 1'b1;
        @(posedge clk);
        #1 we_ifm = 1'b0;
        ifm_m[addr % IFM_DEPTH] = d;
    endtask

    task automatic write_w(input int unsigned addr, input logic [NUM_PE*32-1:0] d);
        @(negedge clk);
        wr_addr = addr; wdata_w = d; we_weight = 1'b1;
        @(posedge clk);
        #1 we_weight = 1'b0;
        for (int p = 0; p < NUM_PE; p++)
            w_m[p][addr % W_DEPTH] = d[32*p +: 32];
    endtask

    function automatic logic [NUM_PE*32-1:0] rand_banks();
        logic [NUM_PE*32-1:0] d;
        for (int p = 0; p < NUM_PE; p++)
            d[32*p +: 32] = $urandom;
        return d;
    endfunction

    // ---------------- job runner ----------------
    task automatic run_job(input string tag, input int k, input int iw, input int cw, input int ow,
                           input int s, input int sh, input int stall, input bit poke,
                           output logic [NUM_PE*8-1:0] first_data);
        int n, total, cyc;
        bit saw_done;
        logic [NUM_PE*8-1:0] exp_d, held;
        n = k*k*cw;
        total = ow*ow;
        saw_done = 1'b0;
        first_data = '0;
        @(negedge clk);
        cfg_kernel_w = 4'(k); cfg_ifm_w = 8'(iw); cfg_cw = 8'(cw);
        cfg_ofm_w = 8'(ow); cfg_stride = 2'(s); cfg_shift = 5'(sh);
        start = 1'b1; ofm_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        // Configuration must already be captured; scramble the inputs.
        cfg_kernel_w = 4'($urandom); cfg_ifm_w = 8'($urandom); cfg_cw = 8'($urandom);
        cfg_ofm_w = 8'($urandom); cfg_stride = 2'($urandom); cfg_shift = 5'($urandom);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy after start: got %b want 1", tag, busy);
        end
        for (int pix = 0; pix < total; pix++) begin
            cyc = 0;
            while (ofm_valid !== 1'b1 && cyc < n + 20) begin
                if (poke && cyc < 4) begin
                    we_ifm = 1'b1; we_weight = 1'b1; wr_addr = 32'(cyc);
                    wdata_ifm = $urandom; wdata_w = rand_banks();
                end else begin
                    we_ifm = 1'b0; we_weight = 1'b0;
                end
                if (done === 1'b1) saw_done = 1'b1;
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
            we_ifm = 1'b0; we_weight = 1'b0;
            checks++;
            if (ofm_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s timeout pixel %0d: ofm_valid got %b want 1 within %0d cycles", tag, pix, ofm_valid, n + 20);
                return;
            end
            checks++;
            if (cyc != n + 2) begin
                errors++;
                $display("FAIL %s latency pixel %0d: got %0d cycles want %0d", tag, pix, cyc, n + 2);
            end
            exp_d = model_pixel(k, iw, cw, s, sh, pix % ow, pix / ow);
            checks++;
            if (ofm_data !== exp_d) begin
                errors++;
                $display("FAIL %s data pixel %0d: got %h want %h", tag, pix, ofm_data, exp_d);
            end
            checks++;
            if (ofm_index !== 16'(pix)) begin
                errors++;
                $display("FAIL %s index: got %0d want %0d", tag, ofm_index, pix);
            end
            if (pix == 0) first_data = ofm_data;
            held = ofm_data;
            for (int i = 0; i < stall; i++) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (ofm_valid !== 1'b1 || ofm_data !== held || ofm_index !== 16'(pix)) begin
                    errors++;
                    $display("FAIL %s stall pixel %0d: got valid=%b data=%h index=%0d want valid=1 data=%h index=%0d",
                             tag, pix, ofm_valid, ofm_data, ofm_index, held, pix);
                end
            end
            ofm_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ofm_ready = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || ofm_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse: got done=%b valid=%b want done=1 valid=0", tag, done, ofm_valid);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done end: got done=%b busy=%b want 0 0", tag, done, busy);
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL %s early done: got done during job want none", tag);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        wr_addr = '0; we_ifm = 1'b0; we_weight = 1'b0; wdata_ifm = '0; wdata_w = '0;
        cfg_kernel_w = '0; cfg_ifm_w = '0; cfg_cw = '0; cfg_ofm_w = '0;
        cfg_stride = '0; cfg_shift = '0; start = 1'b0; ofm_ready = 1'b0;
        for (int i = 0; i < IFM_DEPTH; i++) ifm_m[i] = '0;
        for (int p = 0; p < NUM_PE; p++)
            for (int i = 0; i < W_DEPTH; i++) w_m[p][i] = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++;
        if (ofm_valid !== 1'b0) begin errors++; $display("FAIL reset ofm_valid: got %b want 0", ofm_valid); end
        checks++;
        if (ofm_data !== '0) begin errors++; $display("FAIL reset ofm_data: got %h want 0", ofm_data); end
        checks++;
        if (ofm_index !== '0) begin errors++; $display("FAIL reset ofm_index: got %h want 0", ofm_index); end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [NUM_PE*32-1:0] wb;
        logic [NUM_PE*8-1:0] d;
        wb = rand_banks();
        wb[31:0] = 32'h01010101;
        write_ifm(0, 32'h02020202);
        write_w(0, wb);
        run_job("basic", 1, 1, 1, 1, 0, 0, 0, 1'b0, d);
        checks++;
        if (d[7:0] !== 8'h08) begin
            errors++;
            $display("FAIL basic byte0: got %h want 08", d[7:0]);
        end
    endtask

    task automatic test_saturation();
        logic [NUM_PE*8-1:0] d;
        write_ifm(0, 32'h7F7F7F7F);
        write_w(0, {NUM_PE{32'h7F7F7F7F}});
        run_job("sat_shift0", 1, 1, 1, 1, 1, 0, 0, 1'b0, d);
        checks++;
        if (d[7:0] !== 8'h7F) begin errors++; $display("FAIL sat_shift0 byte0: got %h want 7f", d[7:0]); end
        run_job("sat_shift9", 1, 1, 1, 1, 1, 9, 1, 1'b0, d);
        checks++;
        if (d[7:0] !== 8'h7E) begin errors++; $display("FAIL sat_shift9 byte0: got %h want 7e", d[7:0]); end
    endtask

    task automatic test_negative();
        logic [NUM_PE*8-1:0] d;
        logic [7:0] want;
`ifdef CONV_TILE_RELU_EN
        want = 8'h00;
`else
        want = 8'hFC;
`endif
        write_ifm(0, 32'h01010101);
        write_w(0, {NUM_PE{32'hFFFFFFFF}});
        run_job("negative", 1, 1, 1, 1, 0, 0, 0, 1'b0, d);
        checks++;
        if (d[7:0] !== want) begin errors++; $display("FAIL negative byte0: got %h want %h", d[7:0], want); end
    endtask

    task automatic fill_conv();
        for (int a = 0; a < 64; a++)
            write_ifm(32'(a + IFM_DEPTH * $urandom_range(0, 3)), $urandom);
        for (int a = 0; a < 36; a++)
            write_w(32'(a + W_DEPTH * $urandom_range(0, 3)), rand_banks());
    endtask

    task automatic test_conv_stall();
        logic [NUM_PE*8-1:0] d;
        fill_conv();
        run_job("conv", 3, 4, 4, 2, 1, $urandom_range(4, 10), 5, 1'b0, d);
    endtask

    task automatic test_reset_midrun();
        logic [NUM_PE*8-1:0] d;
        bit bad;
        @(negedge clk);
        cfg_kernel_w = 4'd3; cfg_ifm_w = 8'd4; cfg_cw = 8'd4; cfg_ofm_w = 8'd2;
        cfg_stride = 2'd1; cfg_shift = 5'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ofm_valid !== 1'b0 || ofm_data !== '0 || ofm_index !== '0) begin
            errors++;
            $display("FAIL midrun reset outputs: got busy=%b done=%b valid=%b data=%h index=%h want all 0",
                     busy, done, ofm_valid, ofm_data, ofm_index);
        end
        reset_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ofm_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL midrun quiet: got activity after reset want none"); end
        run_job("rerun", 3, 4, 4, 2, 1, 6, 0, 1'b0, d);
    endtask

    task automatic test_zero_cfg();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            cfg_kernel_w = (t == 0) ? 4'd0 : 4'd2;
            cfg_cw       = (t == 1) ? 8'd0 : 8'd3;
            cfg_ofm_w    = (t == 2) ? 8'd0 : 8'd2;
            cfg_ifm_w = 8'd4; cfg_stride = 2'd1; cfg_shift = 5'd0;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (done !== 1'b1 || busy !== 1'b1 || ofm_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_cfg%0d pulse: got done=%b busy=%b valid=%b want 1 1 0", t, done, busy, ofm_valid);
            end
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || ofm_valid !== 1'b0) begin
                errors++;
                $display("FAIL zero_cfg%0d end: got done=%b busy=%b valid=%b want 0 0 0", t, done, busy, ofm_valid);
            end
        end
    endtask

    task automatic test_write_ignore();
        logic [NUM_PE*8-1:0] d;
        write_ifm(0, $urandom);
        write_w(0, rand_banks());
        run_job("poke", 1, 1, 1, 1, 0, 3, 3, 1'b1, d);
        run_job("after_poke", 1, 1, 1, 1, 0, 3, 0, 1'b0, d);
    endtask

    task automatic test_random();
        logic [NUM_PE*8-1:0] d;
        for (int a = 0; a < IFM_DEPTH; a++) write_ifm(32'(a), $urandom);
        for (int a = 0; a < W_DEPTH; a++) write_w(32'(a), rand_banks());
        for (int it = 0; it < 6; it++)
            run_job($sformatf("rand%0d", it), $urandom_range(1, 3), $urandom_range(1, 10),
                    $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 3),
                    $urandom_range(0, 15), $urandom_range(0, 2), 1'b0, d);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_negative();
        test_conv_stall();
        test_reset_midrun();
        test_zero_cfg();
        test_write_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_tile_engine.md
CONV_TILE_ENGINE -- requirements
Module: conv_tile_engine

Interface
REQ-001 SHALL have parameter NUM_PE, default 16: number of output channels computed in parallel; one weight bank per PE.
REQ-002 SHALL have parameter IFM_DEPTH, default 4096: IFM buffer depth in 32-bit words (power of 2).
REQ-003 SHALL have parameter W_DEPTH, default 1024: per-PE weight buffer depth in 32-bit words (power of 2).
REQ-004 SHALL have parameter ACC_W, default 32: accumulator width in bits.
REQ-005 SHALL have port clk  in  1: the single clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n  in  1: asynchronous, active-low reset.
REQ-007 SHALL have ports wr_addr  in  32, we_ifm  in  1, we_weight  in  1, wdata_ifm  in  32, wdata_w  in  NUM_PE*32 (bank p = bits [32p+31:32p]): buffer load.
REQ-008 SHALL have ports cfg_kernel_w  in  4, cfg_ifm_w  in  8, cfg_cw  in  8 (channel words, 4 int8 channels per word), cfg_ofm_w  in  8, cfg_stride  in  2, cfg_shift  in  5.
REQ-009 SHALL have ports start  in  1, busy  out  1, done  out  1.
REQ-010 SHALL have ports ofm_valid  out  1, ofm_ready  in  1, ofm_data  out  NUM_PE*8 (channel p = bits [8p+7:8p]), ofm_index  out  16 (raster pixel number).

Function
REQ-011 SHALL write buffers only in IDLE: we_ifm writes wdata_ifm to IFM[wr_addr mod IFM_DEPTH]; we_weight writes every bank at wr_addr mod W_DEPTH; writes outside IDLE ignored.
REQ-012 SHALL use FSM states IDLE, RUN, DRAIN, OUT, DONE; start in IDLE samples all cfg_* into internal registers and enters RUN; start elsewhere ignored.
REQ-013 SHALL, per output pixel (x,y), issue N = K*K*cfg_cw reads in order c fastest, then kx, then ky: IFM addr ((y*S+ky)*cfg_ifm_w + x*S+kx)*cfg_cw + c, weight addr (ky*K+kx)*cfg_cw + c, both modulo depth; S=0 treated as 1.
REQ-014 SHALL have 1-cycle buffer read latency; DRAIN lasts exactly 1 cycle, absorbing the final read.
REQ-015 SHALL, per PE, accumulate the sum of 4 signed int8 byte products per word into a signed ACC_W accumulator cleared at pixel start; accumulation wraps at ACC_W.
REQ-016 SHALL produce each output byte as acc arithmetic-shifted right by cfg_shift, saturated to [-128,127].
REQ-017 SHALL, in OUT, assert ofm_valid with ofm_data and ofm_index stable until ofm_ready is high; the transfer completes on the edge where both are high.
REQ-018 SHALL walk pixels in raster order x fastest over cfg_ofm_w x cfg_ofm_w; after the last transfer, enter DONE, pulse done for 1 cycle, then return to IDLE.
REQ-019 SHALL make ofm_valid high exactly N+2 cycles after the start edge for the first pixel, with no idle cycles between pixels beyond the OUT handshake.
REQ-020 SHALL, when K, cfg_cw or cfg_ofm_w equals 0, go directly to DONE with no ofm_valid.
REQ-021 SHALL hold busy high in every state except IDLE.

Reset
REQ-022 SHALL, while reset_n is low, force state IDLE, busy=0, done=0, ofm_valid=0, ofm_data=0, ofm_index=0, accumulators=0; buffer contents are unaffected.
REQ-023 SHALL abort any operation on reset assertion mid-run, with no further ofm_valid or done until a new start.

Configuration
REQ-024 SHALL, with CONV_TILE_RELU_EN defined, clamp every saturated output byte below 0 to 0; without it, signed saturated values are output unchanged.

Verification
REQ-025 SHALL cover: K=1, cfg_cw=1, ofm_w=1, IFM[0]=0x02020202, bank0[0]=0x01010101, shift 0 -> ofm_data byte0=0x08, ofm_valid at start+3, done pulse after transfer.
REQ-026 SHALL cover: IFM=0x7F7F7F7F, weight=0x7F7F7F7F, shift 0 -> byte 0x7F (saturated); shift 9 -> 0x7E.
REQ-027 SHALL cover: IFM=0x01010101, weight=0xFFFFFFFF -> byte 0xFC without CONV_TILE_RELU_EN, 0x00 with it.
REQ-028 SHALL cover: K=3, cfg_cw=4, ifm_w=4, ofm_w=2, stride 1, ofm_ready low 5 cycles per pixel -> 4 outputs indexes 0..3 matching golden model, data stable while stalled.
REQ-029 SHALL cover: reset_n low during RUN of the REQ-028 job -> all outputs 0 next cycle, no done; rerun after start matches golden.
REQ-030 SHALL cover: cfg_cw=0 start -> done pulse, ofm_valid never high; we_ifm during busy -> IFM contents unchanged.
